// File: rtl/strength_resolver_pipe.sv
// -----------------------------------------------------------------------------
// strength_resolver_pipe
//
// Two-stage pipelined resolver for a multi-driver net. Each transaction carries
// N_DRV drivers, each with a logic value and a 3-bit strength code. The result
// is the Verilog strength-resolution outcome: a 4-state value plus the winning
// strength. The block also keeps a saturating count of contention (x) results
// and a sticky flag that records any contention since reset or the last clear.
//
// Strength codes: 0 highz, 1 small, 2 medium, 3 weak, 4 large, 5 pull,
//                 6 strong, 7 supply.
// Result encoding (res_val): 00 = 0, 01 = 1, 10 = z, 11 = x.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_valid        driver vector valid
//   in_ready        pipeline accepts input this cycle
//   drv_val         per-driver logic value, bit i = driver i
//   drv_str         per-driver strength, driver i at [3i+2:3i]
//   out_valid       result valid
//   out_ready       downstream accepts result
//   res_val         resolved value
//   res_str         winning strength (0 when z)
//   cnt_clr         synchronous clear of counter and sticky flag
//   contention_cnt  saturating count of x results accepted downstream
//   contention_seen sticky: an x result was accepted since reset/clear
// -----------------------------------------------------------------------------
module strength_resolver_pipe #(
  parameter int N_DRV = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_DRV-1:0]     drv_val,
  input  logic [3*N_DRV-1:0]   drv_str,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           res_val,
  output logic [2:0]           res_str,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     contention_cnt,
  output logic                 contention_seen
);

  localparam logic [1:0] VAL_0 = 2'b00;
  localparam logic [1:0] VAL_1 = 2'b01;
  localparam logic [1:0] VAL_Z = 2'b10;
  localparam logic [1:0] VAL_X = 2'b11;

  // Strongest strength among drivers currently driving the value 'want'.
  // A highz driver contributes 0, so it can never beat the empty-set result.
  function automatic logic [2:0] max_str(input logic [N_DRV-1:0]   val,
                                         input logic [3*N_DRV-1:0] str,
                                         input logic               want);
    logic [2:0] best;
    best = 3'd0;
    for (int i = 0; i < N_DRV; i++) begin
      if ((val[i] == want) && (str[3*i +: 3] > best)) begin
        best = str[3*i +: 3];
      end
    end
    return best;
  endfunction

  // Compare the strongest 1-driver against the strongest 0-driver.
  // Returns {value[1:0], strength[2:0]}.
  function automatic logic [4:0] resolve(input logic [2:0] s1,
                                         input logic [2:0] s0);
    logic [4:0] r;
    if ((s1 == 3'd0) && (s0 == 3'd0)) begin
      r = {VAL_Z, 3'd0};
    end else if (s1 > s0) begin
      r = {VAL_1, s1};
    end else if (s0 > s1) begin
      r = {VAL_0, s0};
    end else begin
      r = {VAL_X, s1};
    end
    return r;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (&c) begin
      r = c;
    end else begin
      r = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic             advance;
  logic             accept;
  logic             handshake;

  logic [2:0]       s1_p1;
  logic [2:0]       s0_p1;
  logic             vld_p1;
  logic [4:0]       res_p1;

  logic             vld_p2;
  logic [1:0]       res_val_p2;
  logic [2:0]       res_str_p2;

  logic [CNT_W-1:0] cnt;
  logic             seen;

  // The whole pipe moves together; a stalled output freezes every stage,
  // and bubbles are carried rather than squeezed out.
  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign handshake = vld_p2 && out_ready;

  // ---- stage 1: per-value strongest driver ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= accept;
    end
  end

  // Data registers carry no reset; they are only meaningful under vld_p1.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_p1 <= max_str(drv_val, drv_str, 1'b1);
      s0_p1 <= max_str(drv_val, drv_str, 1'b0);
    end
  end

  assign res_p1 = resolve(s1_p1, s0_p1);

  // ---- stage 2: resolved result, drives the outputs ----
  // The result registers are reset so the net reads z while idle after reset;
  // they only load on a valid transaction so bubbles leave them unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2     <= 1'b0;
      res_val_p2 <= VAL_Z;
      res_str_p2 <= 3'd0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_val_p2 <= res_p1[4:3];
        res_str_p2 <= res_p1[2:0];
      end
    end
  end

  assign out_valid = vld_p2;
  assign res_val   = res_val_p2;
  assign res_str   = res_str_p2;

  // ---- contention statistics, counted on the output handshake ----
  // Counting only on handshake means a stalled x result is counted once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      seen <= 1'b0;
    end else if (cnt_clr) begin
      cnt  <= '0;
      seen <= 1'b0;
    end else if (handshake && (res_val_p2 == VAL_X)) begin
      cnt  <= sat_inc(cnt);
      seen <= 1'b1;
    end
  end

  assign contention_cnt  = cnt;
  assign contention_seen = seen;

endmodule

// File: tb/tb_strength_resolver_pipe.sv
// -----------------------------------------------------------------------------
// tb_strength_resolver_pipe
//
// Self-checking bench for strength_resolver_pipe (N_DRV=2, CNT_W=2).
// Directed scenarios followed by randomized traffic, all scored against a
// transaction-level reference: a queue of expected results computed from the
// strength rule, a cycle-count latency rule, and a saturating contention count.
// -----------------------------------------------------------------------------
module tb_strength_resolver_pipe;

  localparam int ND = 2;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ND-1:0]     drv_val = '0;
  logic [3*ND-1:0]   drv_str = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [1:0]        res_val;
  logic [2:0]        res_str;
  logic              cnt_clr = 1'b0;
  logic [CW-1:0]     contention_cnt;
  logic              contention_seen;

  strength_resolver_pipe #(.N_DRV(ND), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .drv_val         (drv_val),
    .drv_str         (drv_str),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .res_val         (res_val),
    .res_str         (res_str),
    .cnt_clr         (cnt_clr),
    .contention_cnt  (contention_cnt),
    .contention_seen (contention_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [2:0] s;
    int         acc_obs;
    int         acc_stall;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         obs_n = 0;
  int         stall_n = 0;
  int         n_pop = 0;
  int         m_cnt = 0;
  logic       m_seen = 1'b0;
  logic       prev_stall = 1'b0;
  logic       sv_ov;
  logic [1:0] sv_val;
  logic [2:0] sv_str;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference resolution: strongest 1 vs strongest 0, ints only.
  function automatic logic [4:0] ref_res(input logic [ND-1:0] v, input logic [3*ND-1:0] s);
    int m1, m0, st;
    logic [4:0] r;
    m1 = 0;
    m0 = 0;
    for (int i = 0; i < ND; i++) begin
      st = int'(s[3*i +: 3]);
      if (v[i]) m1 = (st > m1) ? st : m1;
      else      m0 = (st > m0) ? st : m0;
    end
    if (m1 == 0 && m0 == 0) r = {2'b10, 3'd0};
    else if (m1 > m0)       r = {2'b01, 3'(m1)};
    else if (m0 > m1)       r = {2'b00, 3'(m0)};
    else                    r = {2'b11, 3'(m1)};
    return r;
  endfunction

  // One clock: drive at negedge, observe 1 time unit later, update reference.
  task automatic step(input logic iv, input logic [ND-1:0] dv, input logic [3*ND-1:0] ds,
                      input logic ordy, input logic clr, output logic acc);
    exp_t       e;
    logic       hs;
    logic [4:0] r;
    @(negedge clk);
    in_valid  = iv;
    drv_val   = dv;
    drv_str   = ds;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    chk("cnt", 32'(contention_cnt), 32'(m_cnt));
    chk("seen", 32'(contention_seen), 32'(m_seen));
    chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
    if (prev_stall) begin
      chk("stall_ov", 32'(out_valid), 32'(sv_ov));
      chk("stall_val", 32'(res_val), 32'(sv_val));
      chk("stall_str", 32'(res_str), 32'(sv_str));
    end
    hs = out_valid && out_ready;
    if (out_valid) chk("pending", 32'(q.size() != 0), 32'd1);
    e.v = 2'b00;
    if (hs && q.size() != 0) begin
      e = q.pop_front();
      n_pop++;
      chk("res_val", 32'(res_val), 32'(e.v));
      chk("res_str", 32'(res_str), 32'(e.s));
      chk("latency", obs_n - e.acc_obs, 2 + stall_n - e.acc_stall);
    end
    if (clr) begin
      m_cnt  = 0;
      m_seen = 1'b0;
    end else if (hs && e.v == 2'b11) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      m_seen = 1'b1;
    end
    acc = iv && in_ready;
    if (acc) begin
      r = ref_res(dv, ds);
      e.v = r[4:3];
      e.s = r[2:0];
      e.acc_obs = obs_n;
      e.acc_stall = stall_n;
      q.push_back(e);
    end
    prev_stall = out_valid && !out_ready;
    sv_ov  = out_valid;
    sv_val = res_val;
    sv_str = res_str;
    if (prev_stall) stall_n++;
    obs_n++;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc;
    logic [1:0]    bp_v [4];
    logic [5:0]    bp_s [4];
    int            idx;
    int            pops0;
    logic          iv, ordy, clr;

    // ---- reset values ----
    #12;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_val", 32'(res_val), 32'd2);
    chk("rst_str", 32'(res_str), 32'd0);
    chk("rst_cnt", 32'(contention_cnt), 32'd0);
    chk("rst_seen", 32'(contention_seen), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // ---- supply 1 vs strong 0 ----
    step(1'b1, 2'b01, 6'o67, 1'b1, 1'b0, acc);
    chk("t1_acc", 32'(acc), 32'd1);
    idle(1);
    chk("t1_early_ov", 32'(out_valid), 32'd0);
    idle(1);
    chk("t1_ov", 32'(out_valid), 32'd1);
    chk("t1_val", 32'(res_val), 32'd1);
    chk("t1_str", 32'(res_str), 32'd7);
    chk("t1_cnt", 32'(contention_cnt), 32'd0);

    // ---- equal pull contention ----
    step(1'b1, 2'b01, 6'o55, 1'b1, 1'b0, acc);
    idle(2);
    chk("t2_val", 32'(res_val), 32'd3);
    chk("t2_str", 32'(res_str), 32'd5);
    idle(1);
    chk("t2_cnt", 32'(contention_cnt), 32'd1);
    chk("t2_seen", 32'(contention_seen), 32'd1);

    // ---- all highz, then weak 1 vs highz 0 ----
    step(1'b1, 2'b00, 6'o00, 1'b1, 1'b0, acc);
    step(1'b1, 2'b01, 6'o03, 1'b1, 1'b0, acc);
    idle(1);
    chk("t3_z_val", 32'(res_val), 32'd2);
    chk("t3_z_str", 32'(res_str), 32'd0);
    idle(1);
    chk("t3_w_val", 32'(res_val), 32'd1);
    chk("t3_w_str", 32'(res_str), 32'd3);
    idle(2);

    // ---- backpressure: 4 vectors, 3-cycle stall after first result ----
    bp_v[0] = 2'b01; bp_s[0] = 6'o55;
    bp_v[1] = 2'b01; bp_s[1] = 6'o07;
    bp_v[2] = 2'b10; bp_s[2] = 6'o33;
    bp_v[3] = 2'b00; bp_s[3] = 6'o45;
    idx = 0;
    pops0 = n_pop;
    for (int k = 0; k < 14; k++) begin
      ordy = !(k >= 2 && k <= 4);
      iv = (idx < 4);
      step(iv, iv ? bp_v[idx] : 2'b00, iv ? bp_s[idx] : 6'o00, ordy, 1'b0, acc);
      if (acc) idx++;
      if (k >= 2 && k <= 4) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_ov", 32'(out_valid), 32'd1);
      end
    end
    chk("bp_count", n_pop - pops0, 4);

    // ---- saturation and clear-vs-increment ----
    step(1'b0, '0, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 10; i++) begin
      iv  = (i < 6);
      clr = (i == 7);
      step(iv, 2'b01, 6'o55, 1'b1, clr, acc);
      if (i == 7) begin
        chk("sat_cnt", 32'(contention_cnt), 32'd3);
        chk("sat_seen", 32'(contention_seen), 32'd1);
      end
      if (i == 8) begin
        chk("clr_cnt", 32'(contention_cnt), 32'd0);
        chk("clr_seen", 32'(contention_seen), 32'd0);
      end
    end

    // ---- asynchronous reset with two transactions in flight ----
    step(1'b1, 2'b01, 6'o55, 1'b1, 1'b0, acc);
    idle(3);
    step(1'b1, 2'b01, 6'o07, 1'b1, 1'b0, acc);
    step(1'b1, 2'b10, 6'o70, 1'b1, 1'b0, acc);
    @(posedge clk);
    #2;
    chk("pre_rst_ov", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_val", 32'(res_val), 32'd2);
    chk("arst_str", 32'(res_str), 32'd0);
    chk("arst_cnt", 32'(contention_cnt), 32'd0);
    chk("arst_seen", 32'(contention_seen), 32'd0);
    q.delete();
    m_cnt = 0;
    m_seen = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("post_rst_ov", 32'(out_valid), 32'd0);
    end

    // ---- randomized traffic ----
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), ND'($urandom), (3*ND)'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), acc);
    end

    // ---- drain ----
    idle(8);
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
